// File: rtl/riscv_alu_pkg.sv
// Shared types and constants for the RV32I execute-stage ALU.
// Optional branch flags are enabled with `define ALU_BRANCH_FLAGS_EN.
package riscv_alu_pkg;

    localparam int XLEN = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    function automatic logic [XLEN-1:0] bitRev(input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = d[XLEN-1-i];
        return r;
    endfunction

endpackage

// File: rtl/riscv_alu_shifter.sv
// Shared barrel shifter: one right shifter, left shifts done by reversing
// the operand on the way in and the result on the way out.
module riscv_alu_shifter
    import riscv_alu_pkg::*;
(
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               shiftLeft,
    input  logic               shiftArith,
    output logic [XLEN-1:0]    result
);

    logic [XLEN-1:0] src;
    logic [XLEN-1:0] shifted;
    logic            fill;

    always_comb begin
        src     = shiftLeft ? bitRev(data) : data;
        fill    = shiftArith & ~shiftLeft & data[XLEN-1];
        // Sign fill: set every vacated upper bit when the fill bit is 1.
        shifted = (src >> shamt) | (fill ? ~({XLEN{1'b1}} >> shamt) : '0);
        result  = shiftLeft ? bitRev(shifted) : shifted;
    end

endmodule

// File: rtl/riscv_alu.sv
// Registered RV32I ALU: combinational op mux, one output register stage.
// `define ALU_BRANCH_FLAGS_EN adds registered zero/lt/ltu branch flags.
module riscv_alu #(
    parameter int XLEN = riscv_alu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [3:0]      aluOutSel,
    input  logic            in_valid,
    output logic [XLEN-1:0] aluOut,
    output logic            out_valid
`ifdef ALU_BRANCH_FLAGS_EN
    ,
    output logic            zero,
    output logic            lt,
    output logic            ltu
`endif
);

    import riscv_alu_pkg::alu_op_e;
    import riscv_alu_pkg::SHAMT_W;
    import riscv_alu_pkg::ALU_ADD;
    import riscv_alu_pkg::ALU_SUB;
    import riscv_alu_pkg::ALU_SLL;
    import riscv_alu_pkg::ALU_SLT;
    import riscv_alu_pkg::ALU_SLTU;
    import riscv_alu_pkg::ALU_XOR;
    import riscv_alu_pkg::ALU_SRL;
    import riscv_alu_pkg::ALU_SRA;
    import riscv_alu_pkg::ALU_OR;
    import riscv_alu_pkg::ALU_AND;
    import riscv_alu_pkg::ALU_PASSB;

    localparam int STAGES = 1;

    logic [XLEN-1:0] shiftRes;
    logic [XLEN-1:0] aluNext;
    logic            sLt;
    logic            uLt;
    logic            shiftLeft;
    logic            shiftArith;
    logic [STAGES:0] vldPipe;

    assign sLt        = $signed(opA) < $signed(opB);
    assign uLt        = opA < opB;
    assign shiftLeft  = (aluOutSel == ALU_SLL);
    assign shiftArith = (aluOutSel == ALU_SRA);

    riscv_alu_shifter uShifter (
        .data      (opA),
        .shamt     (opB[SHAMT_W-1:0]),
        .shiftLeft (shiftLeft),
        .shiftArith(shiftArith),
        .result    (shiftRes)
    );

    always_comb begin
        aluNext = '0;
        case (alu_op_e'(aluOutSel))
            ALU_ADD:   aluNext = opA + opB;
            ALU_SUB:   aluNext = opA - opB;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   aluNext = shiftRes;
            ALU_SLT:   aluNext = {{(XLEN-1){1'b0}}, sLt};
            ALU_SLTU:  aluNext = {{(XLEN-1){1'b0}}, uLt};
            ALU_XOR:   aluNext = opA ^ opB;
            ALU_OR:    aluNext = opA | opB;
            ALU_AND:   aluNext = opA & opB;
            ALU_PASSB: aluNext = opB;
            default:   aluNext = '0;
        endcase
    end

    assign vldPipe[0] = in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vldPipe[STAGES:1] <= '0;
            aluOut            <= '0;
        end else begin
            vldPipe[STAGES:1] <= vldPipe[STAGES-1:0];
            // Result holds when no new operation is issued.
            if (in_valid) aluOut <= aluNext;
        end
    end

    assign out_valid = vldPipe[STAGES];

`ifdef ALU_BRANCH_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
            lt   <= 1'b0;
            ltu  <= 1'b0;
        end else if (in_valid) begin
            zero <= (opA == opB);
            lt   <= sLt;
            ltu  <= uLt;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed table, random ops, hold and reset.
// Flag checks are compiled in with `define ALU_BRANCH_FLAGS_EN.
module tb_riscv_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [3:0]  aluOutSel;
    logic        in_valid;
    logic [31:0] aluOut;
    logic        out_valid;
`ifdef ALU_BRANCH_FLAGS_EN
    logic        zero;
    logic        lt;
    logic        ltu;
`endif

    int checks = 0;
    int errors = 0;

    riscv_alu #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opA      (opA),
        .opB      (opB),
        .aluOutSel(aluOutSel),
        .in_valid (in_valid),
        .aluOut   (aluOut),
        .out_valid(out_valid)
`ifdef ALU_BRANCH_FLAGS_EN
        ,
        .zero     (zero),
        .lt       (lt),
        .ltu      (ltu)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the spec's rules.
    function automatic logic [31:0] refAlu(input int sel, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     sh;
        longint ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = int'(b % 32);
        case (sel)
            0:  return 32'((ua + ub) % 64'h1_0000_0000);
            1:  return 32'((ua - ub + 64'h1_0000_0000) % 64'h1_0000_0000);
            2:  return 32'((ua * (64'd1 << sh)) % 64'h1_0000_0000);
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return (ua < ub) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return 32'(ua / (64'd1 << sh));
            7:  begin
                    // Floor division gives sign-filled right shift.
                    longint q;
                    q = sa / (64'sd1 << sh);
                    if (sa < 0 && (sa % (64'sd1 << sh)) != 0) q = q - 1;
                    return 32'(q);
                end
            8:  return a | b;
            9:  return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b, input logic v);
        @(negedge clk);
        aluOutSel = 4'(sel);
        opA       = a;
        opB       = b;
        in_valid  = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; opA = '0; opB = '0; aluOutSel = '0;
        #2;
        checks++;
        if (aluOut !== 32'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_init aluOut=%h out_valid=%b want 0/0", aluOut, out_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        issue(0, 32'd100, 32'd23, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || aluOut !== 32'd123) begin
            errors++;
            $display("FAIL reset_pre aluOut=%h out_valid=%b want 7b/1", aluOut, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (aluOut !== 32'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async aluOut=%h out_valid=%b want 0/0", aluOut, out_valid);
        end
`ifdef ALU_BRANCH_FLAGS_EN
        checks++;
        if ({zero, lt, ltu} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b want 000", {zero, lt, ltu});
        end
`endif
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_directed();
        int          sel [18] = '{0, 1, 1, 0, 3, 3, 4, 4, 2, 6, 7, 7, 5, 8, 9, 10, 15, 11};
        logic [31:0] a   [18] = '{5, 7, 0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 38, 1, 1, 38, 1,
                                  32'h8000_0000, 38, 8, 4, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h1234};
        logic [31:0] b   [18] = '{1, 4, 1, 1, 1, 1, 33, 32'hFFFF_FFFF, 0, 33, 3, 4, 33, 3, 2,
                                  32'h1234_5000, 32'hFFFF_FFFF, 32'h5678};
        logic [31:0] exp [18] = '{6, 3, 32'hFFFF_FFFF, 0, 0, 1, 0, 1, 1, 19, 0, 32'hF800_0000,
                                  7, 11, 0, 32'h1234_5000, 0, 0};
        for (int i = 0; i < 18; i++) begin
            issue(sel[i], a[i], b[i], 1'b1);
            checks++;
            if (aluOut !== exp[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed[%0d] sel=%0d got=%h/%b want=%h/1", i, sel[i], aluOut, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            int          s;
            logic [31:0] a, b, e;
            s = $urandom_range(0, 15);
            a = randOperand();
            b = randOperand();
            e = refAlu(s, a, b);
            issue(s, a, b, 1'b1);
            checks++;
            if (aluOut !== e || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d] sel=%0d a=%h b=%h got=%h/%b want=%h/1", i, s, a, b, aluOut, out_valid, e);
            end
`ifdef ALU_BRANCH_FLAGS_EN
            checks++;
            if (zero !== (a == b) || lt !== ($signed(a) < $signed(b)) || ltu !== (a < b)) begin
                errors++;
                $display("FAIL b2b_flags[%0d] a=%h b=%h got=%b%b%b", i, a, b, zero, lt, ltu);
            end
`endif
        end
    endtask

    task automatic test_hold();
        logic [31:0] kept;
        issue(1, 32'hFFFF_FFFF, 32'd1, 1'b1);
        kept = aluOut;
        checks++;
        if (kept !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL hold_issue got=%h want=fffffffe", kept);
        end
        for (int i = 0; i < 4; i++) begin
            issue($urandom_range(0, 10), $urandom, $urandom, 1'b0);
            checks++;
            if (aluOut !== 32'hFFFF_FFFE || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] got=%h/%b want=fffffffe/0", i, aluOut, out_valid);
            end
        end
    endtask

`ifdef ALU_BRANCH_FLAGS_EN
    task automatic test_flags();
        issue(0, 32'd5, 32'd5, 1'b1);
        checks++;
        if (zero !== 1'b1) begin
            errors++;
            $display("FAIL flags_zero got=%b want=1", zero);
        end
        issue(9, 32'hFFFF_FFFF, 32'd1, 1'b1);
        checks++;
        if (lt !== 1'b1 || ltu !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL flags_lt got=%b%b%b want z0 lt1 ltu0", zero, lt, ltu);
        end
        issue(0, 32'd9, 32'd9, 1'b0);
        checks++;
        if (lt !== 1'b1 || ltu !== 1'b0 || zero !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flags_hold got=%b%b%b/%b want 010/0", zero, lt, ltu, out_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
`ifdef ALU_BRANCH_FLAGS_EN
        test_flags();
`endif
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
